// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI command bridge.
// Holds the decode FSM states, the write opcode and the saturating counter helper.
package spi_bridge_pkg;

   typedef enum logic [1:0] {HDR, DATA, ISSUE} state_t;

   localparam logic [1:0] OP_WRITE = 2'b10;
   localparam int unsigned OP_HI = 31;
   localparam int unsigned OP_LO = 30;
   localparam int unsigned CNT_W = 8;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// Synchronous word FIFO between the frame capture and the command decoder.
// A pop in the same cycle frees a slot for a push into a full FIFO; no bypass when empty.
module spi_word_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/spi_cmd_bridge.sv
// Captures completed SPI frames into the clk domain and decodes header/data
// word pairs into single-beat register write requests with req/ack handshake.
module spi_cmd_bridge
   import spi_bridge_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int SETTLE     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spi_ss,
   input  logic                  spi_valid,
   input  logic [DATA_WIDTH-1:0] spi_data,
   output logic                  wr_req,
   output logic [DATA_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_ack,
   output logic [CNT_W-1:0]      frame_err_cnt,
   output logic [CNT_W-1:0]      cmd_err_cnt,
   output logic [CNT_W-1:0]      ovf_cnt,
   output logic                  busy
);

   localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);

   logic ss_meta, ss_sync, ss_dly, ss_rise;
   logic [2:0] cap_cnt;
   logic cap_busy, cap_fire, frame_err, fifo_push, ovf;
   logic fifo_pop, fifo_full, fifo_empty, cmd_err;
   logic [DATA_WIDTH-1:0] fifo_rd;
   state_t state_q, state_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d, data_q, data_d;

   assign ss_rise   = ss_sync & ~ss_dly;
   // A rise that lands on the sampling cycle wins: the older frame counts as lost.
   assign cap_fire  = cap_busy & ~ss_rise & (cap_cnt == 3'd0);
   assign fifo_push = cap_fire & spi_valid;
   assign frame_err = (cap_fire & ~spi_valid) | (ss_rise & cap_busy);
   assign ovf       = fifo_push & fifo_full & ~fifo_pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ss_meta  <= 1'b1;
         ss_sync  <= 1'b1;
         ss_dly   <= 1'b1;
         cap_cnt  <= '0;
         cap_busy <= 1'b0;
      end else begin
         ss_meta <= spi_ss;
         ss_sync <= ss_meta;
         ss_dly  <= ss_sync;
         if (ss_rise) begin
            cap_cnt  <= SETTLE_CNT;
            cap_busy <= 1'b1;
         end else if (cap_busy) begin
            if (cap_cnt == 3'd0) cap_busy <= 1'b0;
            else                 cap_cnt  <= cap_cnt - 3'd1;
         end
      end
   end

   spi_word_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifo_push),
      .push_data(spi_data),
      .pop      (fifo_pop),
      .pop_data (fifo_rd),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      fifo_pop = 1'b0;
      cmd_err  = 1'b0;
      case (state_q)
         HDR: if (!fifo_empty) begin
            fifo_pop = 1'b1;
            if (fifo_rd[OP_HI:OP_LO] == OP_WRITE) begin
               addr_d  = {fifo_rd[DATA_WIDTH-3:0], 2'b00};
               state_d = DATA;
            end else begin
               cmd_err = 1'b1;
            end
         end
         DATA: if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_rd;
            state_d  = ISSUE;
         end
         ISSUE: if (wr_ack) state_d = HDR;
         default: state_d = HDR;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= HDR;
         addr_q        <= '0;
         data_q        <= '0;
         frame_err_cnt <= '0;
         cmd_err_cnt   <= '0;
         ovf_cnt       <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         frame_err_cnt <= sat_inc(frame_err_cnt, frame_err);
         cmd_err_cnt   <= sat_inc(cmd_err_cnt, cmd_err);
         ovf_cnt       <= sat_inc(ovf_cnt, ovf);
      end
   end

   // Request decoded straight from the state flop so reset drops it asynchronously.
   assign wr_req  = (state_q == ISSUE);
   assign wr_addr = addr_q;
   assign wr_data = data_q;
   assign busy    = ~fifo_empty | (state_q != HDR);

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Directed bench for spi_cmd_bridge: table-driven write pairs plus hand-written
// sequences for invalid frames, bad opcodes, overflow, SS restarts and reset.
module tb_spi_cmd_bridge;

   localparam int SETTLE = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        spi_ss;
   logic        spi_valid;
   logic [31:0] spi_data;
   logic        wr_req;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_ack;
   logic [7:0]  frame_err_cnt;
   logic [7:0]  cmd_err_cnt;
   logic [7:0]  ovf_cnt;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   spi_cmd_bridge #(
      .DATA_WIDTH(32),
      .FIFO_DEPTH(4),
      .SETTLE    (SETTLE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .spi_ss       (spi_ss),
      .spi_valid    (spi_valid),
      .spi_data     (spi_data),
      .wr_req       (wr_req),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ack       (wr_ack),
      .frame_err_cnt(frame_err_cnt),
      .cmd_err_cnt  (cmd_err_cnt),
      .ovf_cnt      (ovf_cnt),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hdr;
      logic [31:0] data;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      int          ack_dly;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [31:0] d, input logic v);
      spi_ss = 1'b0;
      repeat (2) @(negedge clk);
      spi_data  = d;
      spi_valid = v;
      @(negedge clk);
      spi_ss = 1'b1;
      repeat (SETTLE + 6) @(negedge clk);
   endtask

   task automatic wait_req(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (wr_req) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic count_req(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (wr_req) cnt++;
         @(negedge clk);
      end
   endtask

   task automatic do_write(input string tag, input logic [31:0] ea, input logic [31:0] ed, input int dly);
      logic ok;
      wait_req(ok);
      check({tag, "_req_seen"}, 32'(ok), 32'd1);
      if (ok) begin
         check({tag, "_addr"}, wr_addr, ea);
         check({tag, "_data"}, wr_data, ed);
         for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check({tag, "_req_held"}, 32'(wr_req), 32'd1);
            check({tag, "_addr_held"}, wr_addr, ea);
         end
         wr_ack = 1'b1;
         @(negedge clk);
         wr_ack = 1'b0;
         check({tag, "_req_drop"}, 32'(wr_req), 32'd0);
      end
   endtask

   initial begin
      int cnt;
      logic ok;

      vecs[0] = '{32'h80000010, 32'hDEADBEEF, 32'h00000040, 32'hDEADBEEF, 3};
      vecs[1] = '{32'h80000002, 32'h12345678, 32'h00000008, 32'h12345678, 1};
      vecs[2] = '{32'h80003FFF, 32'hA5A5A5A5, 32'h0000FFFC, 32'hA5A5A5A5, 2};
      vecs[3] = '{32'hBFFFFFFF, 32'h00000000, 32'hFFFFFFFC, 32'h00000000, 0};

      reset = 1'b1; spi_ss = 1'b1; spi_valid = 1'b0; spi_data = '0; wr_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req",   32'(wr_req), 32'd0);
      check("rst_addr",  wr_addr, 32'd0);
      check("rst_data",  wr_data, 32'd0);
      check("rst_ferr",  32'(frame_err_cnt), 32'd0);
      check("rst_cerr",  32'(cmd_err_cnt), 32'd0);
      check("rst_ovf",   32'(ovf_cnt), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // table-driven write pairs
      for (int i = 0; i < 4; i++) begin
         send_frame(vecs[i].hdr, 1'b1);
         send_frame(vecs[i].data, 1'b1);
         do_write($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_data, vecs[i].ack_dly);
         repeat (2) @(negedge clk);
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      end
      check("vec_ferr", 32'(frame_err_cnt), 32'd0);
      check("vec_cerr", 32'(cmd_err_cnt), 32'd0);

      // invalid frame
      do_reset();
      send_frame(32'h80000010, 1'b0);
      count_req(10, cnt);
      check("inv_ferr", 32'(frame_err_cnt), 32'd1);
      check("inv_busy", 32'(busy), 32'd0);
      check("inv_noreq", 32'(cnt), 32'd0);

      // bad opcode then valid pair
      do_reset();
      send_frame(32'h40000001, 1'b1);
      send_frame(32'h80000002, 1'b1);
      send_frame(32'h12345678, 1'b1);
      check("bad_cerr", 32'(cmd_err_cnt), 32'd1);
      do_write("bad", 32'h00000008, 32'h12345678, 1);
      count_req(10, cnt);
      check("bad_single", 32'(cnt), 32'd0);

      // back-to-back SS rises restart the capture
      do_reset();
      spi_ss = 1'b0;
      repeat (2) @(negedge clk);
      spi_data = 32'hAAAA0000; spi_valid = 1'b1;
      @(negedge clk);
      spi_ss = 1'b1;
      @(negedge clk);
      spi_ss = 1'b0;
      spi_data = 32'h80000040;
      @(negedge clk);
      spi_ss = 1'b1;
      repeat (SETTLE + 6) @(negedge clk);
      check("b2b_ferr", 32'(frame_err_cnt), 32'd1);
      send_frame(32'h55555555, 1'b1);
      do_write("b2b", 32'h00000100, 32'h55555555, 0);
      check("b2b_cerr", 32'(cmd_err_cnt), 32'd0);

      // FIFO overflow with ack held off
      do_reset();
      send_frame(32'h80000100, 1'b1);
      send_frame(32'h11111111, 1'b1);
      send_frame(32'h80000200, 1'b1);
      send_frame(32'h22222222, 1'b1);
      send_frame(32'h80000300, 1'b1);
      send_frame(32'h33333333, 1'b1);
      send_frame(32'h44444444, 1'b1);
      check("ovf_cnt", 32'(ovf_cnt), 32'd1);
      check("ovf_busy", 32'(busy), 32'd1);
      do_write("ovf1", 32'h00000400, 32'h11111111, 1);
      do_write("ovf2", 32'h00000800, 32'h22222222, 0);
      do_write("ovf3", 32'h00000C00, 32'h33333333, 0);
      count_req(20, cnt);
      check("ovf_noextra", 32'(cnt), 32'd0);
      check("ovf_idle", 32'(busy), 32'd0);
      check("ovf_cerr", 32'(cmd_err_cnt), 32'd0);

      // reset while a request is pending
      do_reset();
      send_frame(32'h80000004, 1'b1);
      send_frame(32'hCAFEF00D, 1'b1);
      wait_req(ok);
      check("rstiss_req_seen", 32'(ok), 32'd1);
      @(negedge clk);
      send_frame(32'h80000005, 1'b1);
      reset = 1'b1;
      #1;
      check("rstiss_req_async", 32'(wr_req), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rstiss_busy", 32'(busy), 32'd0);
      check("rstiss_ferr", 32'(frame_err_cnt), 32'd0);
      check("rstiss_cerr", 32'(cmd_err_cnt), 32'd0);
      check("rstiss_ovf",  32'(ovf_cnt), 32'd0);
      send_frame(32'h80000020, 1'b1);
      send_frame(32'h0BADF00D, 1'b1);
      do_write("rstiss_next", 32'h00000080, 32'h0BADF00D, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
